// File: rtl/cw305_operand_stream_pkg.sv
// cw305_operand_stream_pkg
// Shared types and width helpers for the operand/result store.
//   rd_state_t / wr_state_t : reader and writer engine states
//   clog2_min1              : index width that never collapses to zero
//   calc_nwords/calc_nbytes : derived operand geometry
//   first_idx / next_idx    : word-order aware index sequencing, shared by
//                             the word counter and the reader prefetch path
package cw305_operand_stream_pkg;

  typedef enum logic {R_IDLE, R_STREAM} rd_state_t;
  typedef enum logic {W_IDLE, W_CAPTURE} wr_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_nwords(input int operand_w, input int word_w);
    return operand_w / word_w;
  endfunction

  function automatic int calc_nbytes(input int operand_w);
    return operand_w / 8;
  endfunction

  // MSW-first sequences count down from the top word, LSW-first count up.
  function automatic int first_idx(input int nwords, input logic msw_first);
    return msw_first ? (nwords - 1) : 0;
  endfunction

  function automatic int next_idx(input int idx, input logic msw_first);
    return msw_first ? (idx - 1) : (idx + 1);
  endfunction

endpackage

// File: rtl/cw305_operand_stream_counter.sv
// operand_word_counter
// Loadable up/down word index counter with terminal-count flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a new sequence; direction taken from load_down
//   load_down  : 1 = MSW-first (count down), 0 = LSW-first (count up)
//   step       : advance to the next index of the sequence
//   idx        : current word index
//   tc         : current index is the final one of the sequence
module operand_word_counter
  import cw305_operand_stream_pkg::*;
#(
  parameter int N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         load_down,
  input  logic         step,
  output logic [W-1:0] idx,
  output logic         tc
);

  logic down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      down <= 1'b0;
    end else if (load) begin
      idx  <= W'(first_idx(N, load_down));
      down <= load_down;
    end else if (step) begin
      idx  <= W'(next_idx(int'(idx), down));
    end
  end

  assign tc = (int'(idx) == (down ? 0 : (N - 1)));

endmodule

// File: rtl/cw305_operand_stream.sv
// cw305_operand_stream
// Operand/result store in the crypto clock domain. Holds pNUM_SLOTS operands
// of pOPERAND_WIDTH bits, byte-accessible from the (already synchronised)
// host side, streamed word-wise to a crypto core and refilled from its
// result stream over valid/ready handshakes.
//   crypto_clk, reset_n      : clock, asynchronous active-low reset
//   host_*                   : byte write / registered byte read port
//   rd_start_i, rd_slot_i,
//   rd_msw_first_i           : launch an operand stream
//   out_valid_o/word/last,
//   out_ready_i              : operand stream to the core
//   wr_start_i, wr_slot_i,
//   wr_msw_first_i           : launch a result capture
//   in_valid_i, in_word_i,
//   in_ready_o, wr_done_o    : result stream from the core
//   busy_o, err_o, err_clr_i : status; err_o is sticky until cleared
module cw305_operand_stream
  import cw305_operand_stream_pkg::*;
#(
  parameter int pNUM_SLOTS     = 4,
  parameter int pOPERAND_WIDTH = 256,
  parameter int pWORD_WIDTH    = 32,
  localparam int SLOT_W = clog2_min1(pNUM_SLOTS),
  localparam int NWORDS = calc_nwords(pOPERAND_WIDTH, pWORD_WIDTH),
  localparam int NBYTES = calc_nbytes(pOPERAND_WIDTH),
  localparam int BYTE_W = clog2_min1(NBYTES),
  localparam int IDX_W  = clog2_min1(NWORDS)
) (
  input  logic                   crypto_clk,
  input  logic                   reset_n,
  input  logic                   host_wr_i,
  input  logic [SLOT_W-1:0]      host_slot_i,
  input  logic [BYTE_W-1:0]      host_byte_i,
  input  logic [7:0]             host_wdata_i,
  output logic [7:0]             host_rdata_o,
  input  logic                   rd_start_i,
  input  logic [SLOT_W-1:0]      rd_slot_i,
  input  logic                   rd_msw_first_i,
  output logic                   out_valid_o,
  output logic [pWORD_WIDTH-1:0] out_word_o,
  output logic                   out_last_o,
  input  logic                   out_ready_i,
  input  logic                   wr_start_i,
  input  logic [SLOT_W-1:0]      wr_slot_i,
  input  logic                   wr_msw_first_i,
  input  logic                   in_valid_i,
  input  logic [pWORD_WIDTH-1:0] in_word_i,
  output logic                   in_ready_o,
  output logic                   wr_done_o,
  output logic                   busy_o,
  output logic                   err_o,
  input  logic                   err_clr_i
);

  rd_state_t rd_state, rd_state_n;
  wr_state_t wr_state, wr_state_n;

  logic [SLOT_W-1:0] rd_slot, wr_slot;
  logic              rd_msw;
  logic              rd_active, wr_active;
  logic              rd_hs, wr_hs;
  logic              rd_accept, wr_accept;
  logic              host_locked, err_set;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              rd_tc, wr_tc;
  logic [SLOT_W-1:0] fetch_slot;
  logic [IDX_W-1:0]  fetch_idx;
  logic [pWORD_WIDTH-1:0]    fetch_word;
  logic [pOPERAND_WIDTH-1:0] mem [pNUM_SLOTS];

  assign rd_active = (rd_state == R_STREAM);
  assign wr_active = (wr_state == W_CAPTURE);
  assign rd_hs     = rd_active & out_ready_i;
  assign wr_hs     = wr_active & in_valid_i;

  // Start arbitration: the reader wins a same-cycle tie on one slot, and
  // neither engine may start on a slot the other already holds.
  assign rd_accept = rd_start_i & ~rd_active
                   & ~(wr_active & (wr_slot == rd_slot_i));
  assign wr_accept = wr_start_i & ~wr_active
                   & ~(rd_active & (rd_slot == wr_slot_i))
                   & ~(rd_accept & (rd_slot_i == wr_slot_i));

  assign host_locked = (rd_active & (rd_slot == host_slot_i))
                     | (wr_active & (wr_slot == host_slot_i));

  assign err_set = (rd_start_i & ~rd_accept)
                 | (wr_start_i & ~wr_accept)
                 | (host_wr_i & host_locked);

  operand_word_counter #(.N(NWORDS)) u_rd_cnt (
    .clk       (crypto_clk),
    .rst_n     (reset_n),
    .load      (rd_accept),
    .load_down (rd_msw_first_i),
    .step      (rd_hs),
    .idx       (rd_idx),
    .tc        (rd_tc)
  );

  operand_word_counter #(.N(NWORDS)) u_wr_cnt (
    .clk       (crypto_clk),
    .rst_n     (reset_n),
    .load      (wr_accept),
    .load_down (wr_msw_first_i),
    .step      (wr_hs),
    .idx       (wr_idx),
    .tc        (wr_tc)
  );

  // State registers and per-engine context
  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
      rd_slot  <= '0;
      rd_msw   <= 1'b0;
      wr_slot  <= '0;
    end else begin
      rd_state <= rd_state_n;
      wr_state <= wr_state_n;
      if (rd_accept) begin
        rd_slot <= rd_slot_i;
        rd_msw  <= rd_msw_first_i;
      end
      if (wr_accept) wr_slot <= wr_slot_i;
    end
  end

  always_comb begin
    rd_state_n = rd_state;
    case (rd_state)
      R_IDLE:   if (rd_accept)     rd_state_n = R_STREAM;
      R_STREAM: if (rd_hs && rd_tc) rd_state_n = R_IDLE;
      default:                     rd_state_n = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_n = wr_state;
    case (wr_state)
      W_IDLE:    if (wr_accept)     wr_state_n = W_CAPTURE;
      W_CAPTURE: if (wr_hs && wr_tc) wr_state_n = W_IDLE;
      default:                      wr_state_n = W_IDLE;
    endcase
  end

  // The word register is loaded one step ahead of the counter so the first
  // word appears with out_valid_o and each following word directly after
  // its predecessor's handshake.
  always_comb begin
    fetch_slot = rd_accept ? rd_slot_i : rd_slot;
    fetch_idx  = rd_accept ? IDX_W'(first_idx(NWORDS, rd_msw_first_i))
                           : IDX_W'(next_idx(int'(rd_idx), rd_msw));
    fetch_word = mem[fetch_slot][fetch_idx*pWORD_WIDTH +: pWORD_WIDTH];
  end

  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_word_o <= '0;
    end else if (rd_accept || (rd_hs && !rd_tc)) begin
      out_word_o <= fetch_word;
    end
  end

  assign out_valid_o = rd_active;
  assign out_last_o  = rd_active & rd_tc;
  assign in_ready_o  = wr_active;

  // Storage: the capture write is issued last so it wins any overlap.
  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < pNUM_SLOTS; s++) mem[s] <= '0;
    end else begin
      if (host_wr_i && !host_locked)
        mem[host_slot_i][host_byte_i*8 +: 8] <= host_wdata_i;
      if (wr_hs)
        mem[wr_slot][wr_idx*pWORD_WIDTH +: pWORD_WIDTH] <= in_word_i;
    end
  end

  // Status and host read-back
  always_ff @(posedge crypto_clk or negedge reset_n) begin
    if (!reset_n) begin
      host_rdata_o <= '0;
      wr_done_o    <= 1'b0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      host_rdata_o <= mem[host_slot_i][host_byte_i*8 +: 8];
      wr_done_o    <= wr_hs & wr_tc;
      busy_o       <= (rd_state_n != R_IDLE) | (wr_state_n != W_IDLE);
      err_o        <= err_set | (err_o & ~err_clr_i);
    end
  end

endmodule
